// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and sequencer state type for the ALU command
// sequencer and its FIFO.
package alu_pkg;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers and an occupancy count.
// A push while full or a pop while empty is ignored.
module alu_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity,
    // and leaving the array unreset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an external combinational ALU: queues commands, drives them
// into the ALU one at a time and registers each result behind valid/ready.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [DATA_W-1:0]               cmd_a,
    input  logic [DATA_W-1:0]               cmd_b,
    input  logic [2:0]                      cmd_ctrl,
    output logic [DATA_W-1:0]               alu_a,
    output logic [DATA_W-1:0]               alu_b,
    output logic [2:0]                      alu_ctrl,
    input  logic [DATA_W-1:0]               alu_y,
    input  logic                            alu_negative,
    input  logic                            alu_carry,
    input  logic                            alu_zero,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [DATA_W-1:0]               res_y,
    output logic [2:0]                      res_ctrl,
    output logic                            res_negative,
    output logic                            res_carry,
    output logic                            res_zero,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] cmd_count,
    output logic                            busy
);

    localparam int CMD_W = 2 * DATA_W + 3;

    seq_state_t       state;
    logic [CMD_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || (cmd_count != '0);
    // A new command is taken from idle, or straight after a result handshake.
    assign load      = !fifo_empty && ((state == IDLE) || (state == RESULT && res_ready));

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (load),
        .wdata ({cmd_ctrl, cmd_b, cmd_a}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cmd_count)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= CTRL_NOP;
            res_valid    <= 1'b0;
            res_y        <= '0;
            res_ctrl     <= CTRL_NOP;
            res_negative <= 1'b0;
            res_carry    <= 1'b0;
            res_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        alu_a    <= head[DATA_W-1:0];
                        alu_b    <= head[2*DATA_W-1:DATA_W];
                        alu_ctrl <= head[CMD_W-1 -: 3];
                        state    <= EXEC;
                    end else begin
                        alu_ctrl <= CTRL_NOP;
                    end
                end
                EXEC: begin
                    res_y        <= alu_y;
                    res_ctrl     <= alu_ctrl;
                    res_negative <= alu_negative;
                    res_carry    <= alu_carry;
                    res_zero     <= alu_zero;
                    res_valid    <= 1'b1;
                    state        <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (load) begin
                            alu_a    <= head[DATA_W-1:0];
                            alu_b    <= head[2*DATA_W-1:DATA_W];
                            alu_ctrl <= head[CMD_W-1 -: 3];
                            state    <= EXEC;
                        end else begin
                            alu_ctrl <= CTRL_NOP;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU beside the sequencer, directed cases
// followed by random traffic against an in-order scoreboard.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       n;
        logic       c;
        logic       z;
    } alu_res_t;

    typedef struct packed {
        logic [2:0] ctrl;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_ctrl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_y;
    logic       alu_negative;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic [2:0] res_ctrl;
    logic       res_negative;
    logic       res_carry;
    logic       res_zero;
    logic [2:0] cmd_count;
    logic       busy;

    int   n_assert  = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    int   n_pushed  = 0;
    cmd_t exp_q[$];

    alu_cmd_sequencer #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_ctrl     (cmd_ctrl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_y        (alu_y),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_y        (res_y),
        .res_ctrl     (res_ctrl),
        .res_negative (res_negative),
        .res_carry    (res_carry),
        .res_zero     (res_zero),
        .cmd_count    (cmd_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 9-bit sum for carry, borrow (a<b) as SUB carry; other opcodes give all zeros.
    function automatic alu_res_t ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ctrl);
        alu_res_t   r;
        logic [8:0] wide;
        r = '0;
        case (ctrl)
            CTRL_AND: r.y = a & b;
            CTRL_OR:  r.y = a | b;
            CTRL_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r.y  = wide[7:0];
                r.c  = wide[8];
            end
            CTRL_SUB: begin
                r.y = a - b;
                r.c = (a < b);
            end
            default: return '0;
        endcase
        r.n = r.y[7];
        r.z = (r.y == 8'd0);
        return r;
    endfunction

    alu_res_t alu_out;
    always_comb begin
        alu_out      = ref_alu(alu_a, alu_b, alu_ctrl);
        alu_y        = alu_out.y;
        alu_negative = alu_out.n;
        alu_carry    = alu_out.c;
        alu_zero     = alu_out.z;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, advance, verify held results.
    task automatic cycle();
        cmd_t       c;
        alu_res_t   r;
        logic       held;
        logic [14:0] prev;
        held = res_valid && !res_ready;
        prev = {res_y, res_ctrl, res_negative, res_carry, res_zero};
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back('{ctrl: cmd_ctrl, b: cmd_b, a: cmd_a});
            n_pushed++;
        end
        if (res_valid && res_ready) begin
            check("sb_result_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                c = exp_q.pop_front();
                r = ref_alu(c.a, c.b, c.ctrl);
                check("sb_y",    32'(res_y),        32'(r.y));
                check("sb_ctrl", 32'(res_ctrl),     32'(c.ctrl));
                check("sb_neg",  32'(res_negative), 32'(r.n));
                check("sb_cy",   32'(res_carry),    32'(r.c));
                check("sb_zero", 32'(res_zero),     32'(r.z));
            end
            n_results++;
        end
        @(posedge clk);
        #1;
        if (held) begin
            check("hold_valid", 32'(res_valid), 32'(1));
            check("hold_data", 32'({res_y, res_ctrl, res_negative, res_carry, res_zero}), 32'(prev));
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ctrl);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_ctrl  = ctrl;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_in_budget", 32'(k < budget), 32'(1));
    endtask

    initial begin
        int start_res;
        int start_push;
        int cyc;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_ctrl  = '0;
        res_ready = 1'b0;
        #3;
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_count",     32'(cmd_count), 32'(0));
        check("rst_alu_ctrl",  32'(alu_ctrl),  32'(3'b111));
        check("rst_res_ctrl",  32'(res_ctrl),  32'(3'b111));
        check("rst_res_y",     32'(res_y),     32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset while a result is pending and a command is queued.
        cmd_valid = 1'b1; cmd_a = 8'd7; cmd_b = 8'd9; cmd_ctrl = CTRL_ADD;
        cycle();
        cmd_a = 8'd1; cmd_b = 8'd2; cmd_ctrl = CTRL_OR;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        check("pre_rst_res_valid", 32'(res_valid), 32'(1));
        check("pre_rst_count",     32'(cmd_count), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_res_valid", 32'(res_valid), 32'(0));
        check("async_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("async_rst_count",     32'(cmd_count), 32'(0));
        check("async_rst_alu_ctrl",  32'(alu_ctrl),  32'(3'b111));
        check("async_rst_busy",      32'(busy),      32'(0));
        exp_q.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD 200+100 with latency check.
        res_ready = 1'b1;
        issue(8'd200, 8'd100, CTRL_ADD);
        check("add_valid_e0", 32'(res_valid), 32'(0));
        cycle();
        check("add_valid_e1", 32'(res_valid), 32'(0));
        check("add_alu_a",    32'(alu_a),     32'(200));
        cycle();
        check("add_valid_e2", 32'(res_valid), 32'(1));
        check("add_y",        32'(res_y),     32'(44));
        check("add_carry",    32'(res_carry), 32'(1));
        check("add_zero",     32'(res_zero),  32'(0));
        drain(10);

        // SUB equal operands, then SUB with borrow.
        issue(8'd5, 8'd5, CTRL_SUB);
        cycle();
        cycle();
        check("sub0_y",     32'(res_y),        32'(0));
        check("sub0_zero",  32'(res_zero),     32'(1));
        check("sub0_carry", 32'(res_carry),    32'(0));
        check("sub0_neg",   32'(res_negative), 32'(0));
        drain(10);
        issue(8'd3, 8'd5, CTRL_SUB);
        cycle();
        cycle();
        check("sub1_y",     32'(res_y),        32'(254));
        check("sub1_carry", 32'(res_carry),    32'(1));
        check("sub1_neg",   32'(res_negative), 32'(1));
        check("sub1_zero",  32'(res_zero),     32'(0));
        drain(10);

        // Back-pressure: six pushes with the consumer stalled.
        res_ready  = 1'b0;
        start_res  = n_results;
        start_push = n_pushed;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(37 * i + 11);
            cmd_b     = 8'(53 * i + 90);
            case (i % 4)
                0:       cmd_ctrl = CTRL_ADD;
                1:       cmd_ctrl = CTRL_SUB;
                2:       cmd_ctrl = CTRL_AND;
                default: cmd_ctrl = CTRL_OR;
            endcase
            cycle();
        end
        cmd_valid = 1'b0;
        check("bp_accepted",  32'(n_pushed - start_push), 32'(5));
        check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
        check("bp_count",     32'(cmd_count), 32'(4));
        check("bp_first_y",   32'(res_y),     32'(8'd11 + 8'd90));
        repeat (3) cycle();
        res_ready = 1'b1;
        drain(40);
        check("bp_results", 32'(n_results - start_res), 32'(5));

        // Unused opcode passes through; busy falls right after the final handshake.
        res_ready = 1'b0;
        issue(8'd255, 8'd1, 3'b011);
        cycle();
        cycle();
        check("nop_res_valid", 32'(res_valid),    32'(1));
        check("nop_res_ctrl",  32'(res_ctrl),     32'(3'b011));
        check("nop_flag_n",    32'(res_negative), 32'(0));
        check("nop_flag_c",    32'(res_carry),    32'(0));
        check("nop_flag_z",    32'(res_zero),     32'(0));
        check("nop_busy_pre",  32'(busy),         32'(1));
        res_ready = 1'b1;
        cycle();
        check("nop_busy_post", 32'(busy),      32'(0));
        check("nop_alu_ctrl",  32'(alu_ctrl),  32'(3'b111));
        check("nop_res_valid_clr", 32'(res_valid), 32'(0));

        // Random traffic.
        start_res  = n_results;
        start_push = n_pushed;
        cyc = 0;
        while ((n_results - start_res) < 1000 && cyc < 30000) begin
            cmd_valid = ((n_pushed - start_push) < 1000) && ($urandom_range(0, 3) != 0);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_ctrl  = 3'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 2) != 0);
            cycle();
            cyc++;
        end
        cmd_valid = 1'b0;
        check("rand_results", 32'(n_results - start_res), 32'(1000));
        check("rand_queue_empty", 32'(exp_q.size()), 32'(0));
        res_ready = 1'b1;
        cycle();
        check("rand_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
